// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU and a loader port,
// with three-phase IDLE/ADDR/DATA transactions, round-robin fairness and a bounded loader burst lock.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_wait,
   input  logic              ld_req,
   input  logic              ld_wr,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_lock,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nx;
   logic [7:0] burst_cnt;
   logic req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata, cpu_rdata_q, ld_rdata_q;
   logic burst_ok, ld_win, in_data;
   always_comb begin
      burst_ok = burst_cnt < 8'(MAX_BURST);
      // loader wins when alone, on its round-robin turn, or while its lock has burst budget left
      ld_win   = ld_req & (~cpu_req | ~owner | (ld_lock & burst_ok));
      in_data  = state == DATA;
      state_nx = state == IDLE ? ((cpu_req | ld_req) ? ADDR : IDLE) :
                 state == ADDR ? DATA : IDLE;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
      mem_wr    = (state == ADDR) & req_wr;
      cpu_ack   = in_data & ~owner;
      ld_ack    = in_data & owner;
      cpu_rdata = (cpu_ack & ~req_wr) ? mem_rdata : cpu_rdata_q;
      ld_rdata  = (ld_ack & ~req_wr) ? mem_rdata : ld_rdata_q;
      cpu_wait  = cpu_req & ~cpu_ack;
   end
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b1;
         burst_cnt   <= '0;
         req_wr      <= 1'b0;
         req_addr    <= '0;
         req_wdata   <= '0;
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE) begin
            if (cpu_req | ld_req) begin
               owner     <= ld_win;
               req_wr    <= ld_win ? ld_wr : cpu_wr;
               req_addr  <= ld_win ? ld_addr : cpu_addr;
               req_wdata <= ld_win ? ld_wdata : cpu_wdata;
            end
            burst_cnt <= (cpu_req & ld_win) ? (burst_ok ? burst_cnt + 8'd1 : burst_cnt) : '0;
         end
         if (in_data & ~req_wr & ~owner) cpu_rdata_q <= mem_rdata;
         if (in_data & ~req_wr & owner) ld_rdata_q <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps with an ack scoreboard against a behavioural synchronous memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   logic Clk = 0, reset = 1, preload = 1;
   logic cpu_req = 0, cpu_wr = 0, ld_req = 0, ld_wr = 0, ld_lock = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0, mem_rdata;
   logic cpu_ack, cpu_wait, ld_ack, mem_wr, owner;
   logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
   logic [31:0] mem [256];
   typedef struct {logic who; logic [31:0] rd;} exp_t;
   exp_t q[$];
   exp_t e_m, e_s;
   longint ack_t[$];
   int checks = 0, failures = 0, acks = 0, wr_cycles = 0, n = 0, w0 = 0, k = 0;
   logic [31:0] exp_cpu = 0, exp_ld = 0;

   mem_port_arbiter dut (
      .Clk(Clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
      .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (preload) begin
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h30] <= 32'hCAFEF00D;
         mem[8'h40] <= 32'hAAAAAAAA;
      end else if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_ack(input logic who, input logic [31:0] rd);
      exp_t t;
      t.who = who;
      t.rd  = rd;
      q.push_back(t);
   endtask

   always @(negedge Clk) begin
      if (!reset) begin
         if (mem_wr) wr_cycles++;
         if (cpu_ack | ld_ack) begin
            acks++;
            ack_t.push_back($time);
            if (q.size() == 0) check("unexpected_ack", {62'd0, cpu_ack, ld_ack}, 64'd0);
            else begin
               e_m = q.pop_front();
               check("ack_onehot", {63'd0, cpu_ack & ld_ack}, 64'd0);
               check("ack_port", {63'd0, ld_ack}, {63'd0, e_m.who});
               check("ack_rdata", e_m.who ? ld_rdata : cpu_rdata, e_m.rd);
            end
         end
      end
   end

   task automatic wait_acks(input int cnt, input int budget);
      int i;
      i = 0;
      while (acks < cnt && i < budget) begin
         @(posedge Clk);
         i++;
      end
      check("ack_timeout", acks >= cnt, 1);
      #1;
   endtask

   task automatic access(input logic who, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
      if (who) begin ld_req = 1; ld_wr = wr; ld_addr = a; ld_wdata = d; end
      else begin cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
      if (!wr) begin
         if (who) exp_ld = rd; else exp_cpu = rd;
      end
      expect_ack(who, who ? exp_ld : exp_cpu);
      wait_acks(acks + 1, 20);
      if (who) ld_req = 0; else cpu_req = 0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_req = 1;
      repeat (2) @(negedge Clk);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_owner", owner, 1);
      check("rst_acks", {cpu_ack, ld_ack}, 0);
      check("rst_rdata", {cpu_rdata, ld_rdata}, 0);
      check("rst_wait_hi", cpu_wait, 1);
      cpu_req = 0;
      #1 check("rst_wait_lo", cpu_wait, 0);
      @(posedge Clk); #1 reset = 0; preload = 0;
      // CPU read alone with cycle-exact timing
      @(posedge Clk); #1
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
      exp_cpu = 32'hDEADBEEF;
      expect_ack(0, exp_cpu);
      @(negedge Clk);
      check("t1_wait_idle", cpu_wait, 1);
      @(negedge Clk);
      check("t1_addr", mem_addr, 32'h10);
      check("t1_owner", owner, 0);
      check("t1_noack", cpu_ack, 0);
      check("t1_wait_addr", cpu_wait, 1);
      @(negedge Clk);
      check("t1_ack", cpu_ack, 1);
      check("t1_wait_data", cpu_wait, 0);
      @(posedge Clk); #1 cpu_req = 0;
      @(negedge Clk);
      check("t1_rdata_held", cpu_rdata, 32'hDEADBEEF);
      check("t1_ack_pulse", cpu_ack, 0);
      // loader write then CPU read
      w0 = wr_cycles;
      @(posedge Clk); #1
      access(1, 1, 32'h20, 32'h12345678, 0);
      check("t2_wr_cycles", wr_cycles - w0, 1);
      check("t2_mem20", mem[8'h20], 32'h12345678);
      access(0, 0, 32'h20, 0, 32'h12345678);
      access(1, 0, 32'h10, 0, 32'hDEADBEEF);
      // contention without lock, owner is loader so CPU goes first
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
      ld_req = 1; ld_wr = 0; ld_addr = 32'h20;
      exp_cpu = 32'hDEADBEEF; exp_ld = 32'h12345678;
      k = ack_t.size();
      for (int i = 0; i < 2; i++) begin
         expect_ack(0, exp_cpu);
         expect_ack(1, exp_ld);
      end
      wait_acks(acks + 4, 40);
      cpu_req = 0; ld_req = 0;
      for (int i = 1; i < 4; i++)
         if (ack_t.size() > k + i) check("t3_spacing", ack_t[k + i] - ack_t[k + i - 1], 30);
      // locked loader bursts, twice to show the count clears on the CPU grant
      access(0, 0, 32'h10, 0, 32'hDEADBEEF);
      ld_lock = 1; cpu_req = 1; ld_req = 1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) expect_ack(1, exp_ld);
         expect_ack(0, exp_cpu);
      end
      wait_acks(acks + 18, 100);
      cpu_req = 0; ld_req = 0; ld_lock = 0;
      // request changed mid-transaction
      @(posedge Clk); #1
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
      expect_ack(0, 32'hDEADBEEF);
      @(posedge Clk); #1 cpu_addr = 32'h30;
      @(negedge Clk);
      check("t5_addr_addr", mem_addr, 32'h10);
      @(negedge Clk);
      check("t5_data_addr", mem_addr, 32'h10);
      check("t5_ack", cpu_ack, 1);
      @(posedge Clk); #1 cpu_req = 0;
      // reset during ADDR of a write
      @(posedge Clk); #1
      cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = 32'h55555555;
      repeat (2) @(negedge Clk);
      check("t6_mem_wr", mem_wr, 1);
      #1 reset = 1; cpu_req = 0;
      #1;
      check("t6_rst_mem_wr", mem_wr, 0);
      check("t6_rst_addr", mem_addr, 0);
      check("t6_rst_wdata", mem_wdata, 0);
      check("t6_rst_owner", owner, 1);
      check("t6_rst_ack", {cpu_ack, ld_ack}, 0);
      check("t6_rst_rdata", {cpu_rdata, ld_rdata}, 0);
      @(posedge Clk); #1 reset = 0;
      exp_cpu = 0; exp_ld = 0;
      check("t6_mem40", mem[8'h40], 32'hAAAAAAAA);
      @(posedge Clk); #1
      access(0, 0, 32'h40, 0, 32'hAAAAAAAA);
      repeat (4) @(posedge Clk);
      check("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between two masters: the multicycle CPU (fetch and load/store traffic selected by IorD) and a loader/debug port that preloads or inspects memory. Each access is sequenced as a fixed three-phase transaction with a registered grant. Round-robin fairness applies, with a bounded loader burst lock. The block sits between the CPU datapath's address/write-data muxes and the memory. It returns a stall to the control FSM while the CPU waits.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive loader grants while cpu_req is pending (range 1..255)

Ports:
- Clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  access complete (one-cycle pulse)
- cpu_rdata  out  DATA_W  read data
- cpu_wait  out  1  stall to control FSM
- ld_req, ld_wr, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request, same semantics as the CPU port
- ld_lock  in  1  loader requests consecutive grants
- ld_ack  out  1  loader access complete
- ld_rdata  out  DATA_W  loader read data
- mem_addr  out  ADDR_W  memory address
- mem_wr  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after the address is sampled
- owner  out  1  current/last grant (0 = CPU, 1 = loader)

## Operation
- FSM states: IDLE, ADDR, DATA. Every transaction follows IDLE -> ADDR -> DATA -> IDLE. There is no DATA->ADDR shortcut.
- IDLE, at the clock edge: if any request is sampled, latch the winner's wr/addr/wdata into an internal request register, set owner, and go to ADDR. Otherwise stay in IDLE.
- Arbitration in IDLE:
  - If only one request is present, that requester wins.
  - If both request, and ld_lock=1, owner=1, and burst_cnt < MAX_BURST, the loader wins.
  - Otherwise the requester opposite to owner wins (round-robin).
- burst_cnt:
  - Increments on each loader grant made while cpu_req=1, saturating at MAX_BURST.
  - Clears on any CPU grant.
  - Clears on any IDLE cycle with cpu_req=0.
- ADDR: mem_addr and mem_wdata are driven from the latched request. mem_wr equals the latched wr for this cycle only.
- DATA:
  - mem_wr=0 and mem_addr is held.
  - The owner's ack is asserted combinationally.
  - The owner's rdata is driven from mem_rdata during this cycle and captured into the owner's rdata register at the edge.
  - For writes, the rdata register is unchanged; rdata shows the register value.
- Outside DATA, cpu_rdata and ld_rdata present their held registers. mem_addr and mem_wdata hold the last latched request.
- cpu_wait = cpu_req & ~(state==DATA & owner==0).
- Request inputs are sampled only in IDLE. Changing or dropping req/addr/wdata during ADDR or DATA has no effect, and the latched access still completes and acks.
- A requester holding req high after its ack cycle is treated as a new request in the following IDLE.

## Timing
- Reset (asynchronous, immediate) values:
  - state=IDLE, owner=1 (the CPU wins the first tie), burst_cnt=0.
  - mem_wr=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=0, ld_ack=0, cpu_rdata=0, ld_rdata=0.
  - cpu_wait follows cpu_req.
- Reset mid-transaction aborts the access. mem_wr drops immediately and no ack is issued. The requester must re-request.
- Latency: req sampled high in IDLE at edge n -> ADDR in cycle n+1 -> DATA/ack in cycle n+2.
- Throughput: one access per 3 cycles.
- Worst-case CPU wait when contending with a locked loader: the CPU is granted within MAX_BURST loader transactions.
- A simultaneous first request from both masters out of reset goes to the CPU.

## Test plan
- CPU read alone: mem preloaded [0x10]=0xDEADBEEF; cpu_req rd 0x10 -> ADDR next cycle with mem_addr=0x10, cpu_ack plus cpu_rdata=0xDEADBEEF two cycles after request, cpu_wait low only in the ack cycle.
- Loader write then CPU read: ld write 0x20<-0x12345678 (mem_wr exactly one cycle), then CPU read 0x20 -> cpu_rdata=0x12345678.
- Contention without lock: both requests held continuously -> grants alternate CPU, LD, CPU, LD; each ack comes 3 cycles apart.
- Burst lock with MAX_BURST=8: ld_lock=1 with both requesting after a loader grant -> exactly 8 loader acks, then a CPU grant; burst_cnt returns to 0.
- Request changed mid-transaction: cpu_addr switched from 0x10 to 0x30 during ADDR -> access and ack still target 0x10.
- Reset in ADDR of a write: memory location unchanged, no ack, all outputs at reset values, next request served normally.
